// File: rtl/text_write_sched.sv
// ============================================================================
// text_write_sched
// ----------------------------------------------------------------------------
// Purpose:
//   Merges two character producers (A and B, one of them the harmonica) onto
//   the single charsel/valid write channel of the text display. Ownership of
//   the channel is held for a whole line, so the two producers' lines never
//   interleave. The block tracks a cursor (column/row), turns NEWLINE into a
//   cursor move instead of a display write, wraps at the end of a row and at
//   the bottom of the screen, and only accepts characters while the vertical
//   sync write window is open.
//
// Ports:
//   phi            in   system clock, all state on rising edge
//   rst_n          in   asynchronous active-low reset
//   a_char[6:0]    in   producer A character
//   a_valid        in   producer A character present
//   a_ready        out  producer A character accepted this cycle (comb)
//   b_char[6:0]    in   producer B character
//   b_valid        in   producer B character present
//   b_ready        out  producer B character accepted this cycle (comb)
//   vsync          in   display vertical sync, defines the write window
//   home           in   synchronous cursor home (col=0,row=0)
//   charsel[6:0]   out  character to display, registered
//   wrcol[6:0]     out  write column, registered
//   wrrow[4:0]     out  write row, registered
//   valid          out  one-cycle write strobe, registered
//   owner[1:0]     out  00 idle, 01 A, 10 B
// ============================================================================
module text_write_sched #(
  parameter int         COLS       = 80,
  parameter int         ROWS       = 30,
  parameter logic [6:0] NEWLINE    = 7'h0A,
  parameter bit         GATE_VSYNC = 1'b1,
  parameter bit         VS_ACT     = 1'b0
) (
  input  logic       phi,
  input  logic       rst_n,
  input  logic [6:0] a_char,
  input  logic       a_valid,
  output logic       a_ready,
  input  logic [6:0] b_char,
  input  logic       b_valid,
  output logic       b_ready,
  input  logic       vsync,
  input  logic       home,
  output logic [6:0] charsel,
  output logic [6:0] wrcol,
  output logic [4:0] wrrow,
  output logic       valid,
  output logic [1:0] owner
);

  // The state encoding doubles as the owner output.
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    OWN_A = 2'b01,
    OWN_B = 2'b10
  } state_t;

  localparam logic       PTR_A    = 1'b0;
  localparam logic       PTR_B    = 1'b1;
  localparam logic [6:0] LAST_COL = 7'(COLS - 1);
  localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);

  state_t     r_state;
  state_t     w_nextState;
  logic       r_rrPtr;
  logic       w_nextRrPtr;
  logic [6:0] r_col;
  logic [4:0] r_row;
  logic [6:0] r_charsel;
  logic [6:0] r_wrcol;
  logic [4:0] r_wrrow;
  logic       r_valid;

  logic       w_win;
  logic       w_aReady;
  logic       w_bReady;
  logic       w_accept;
  logic [6:0] w_acceptChar;
  logic       w_isNewline;

  assign w_win = GATE_VSYNC ? (vsync == VS_ACT) : 1'b1;

  // Arbitration and ownership. In IDLE the grant cycle also accepts the
  // winner's first character; a NEWLINE accepted on the grant cycle is a
  // one-character line, so ownership is released straight away. While the
  // window is closed nothing is accepted and nothing is released, which lets
  // an owner resume its line in the next window.
  always_comb begin
    w_nextState  = r_state;
    w_nextRrPtr  = r_rrPtr;
    w_aReady     = 1'b0;
    w_bReady     = 1'b0;
    w_accept     = 1'b0;
    w_acceptChar = 7'd0;
    case (r_state)
      IDLE: begin
        if (w_win) begin
          if (a_valid && (!b_valid || r_rrPtr == PTR_A)) begin
            w_aReady     = 1'b1;
            w_accept     = 1'b1;
            w_acceptChar = a_char;
            if (a_char == NEWLINE) begin
              w_nextRrPtr = PTR_B;
            end else begin
              w_nextState = OWN_A;
            end
          end else if (b_valid) begin
            w_bReady     = 1'b1;
            w_accept     = 1'b1;
            w_acceptChar = b_char;
            if (b_char == NEWLINE) begin
              w_nextRrPtr = PTR_A;
            end else begin
              w_nextState = OWN_B;
            end
          end
        end
      end
      OWN_A: begin
        if (w_win) begin
          if (a_valid) begin
            w_aReady     = 1'b1;
            w_accept     = 1'b1;
            w_acceptChar = a_char;
            if (a_char == NEWLINE) begin
              w_nextState = IDLE;
              w_nextRrPtr = PTR_B;
            end
          end else begin
            w_nextState = IDLE;
            w_nextRrPtr = PTR_B;
          end
        end
      end
      OWN_B: begin
        if (w_win) begin
          if (b_valid) begin
            w_bReady     = 1'b1;
            w_accept     = 1'b1;
            w_acceptChar = b_char;
            if (b_char == NEWLINE) begin
              w_nextState = IDLE;
              w_nextRrPtr = PTR_A;
            end
          end else begin
            w_nextState = IDLE;
            w_nextRrPtr = PTR_A;
          end
        end
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  assign w_isNewline = (w_acceptChar == NEWLINE);

  // Ready is forced low while reset is held so a producer never sees a
  // handshake complete that the block is about to discard.
  assign a_ready = w_aReady & rst_n;
  assign b_ready = w_bReady & rst_n;

  // State, round-robin pointer and the registered write channel.
  always_ff @(posedge phi or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_rrPtr   <= PTR_A;
      r_charsel <= 7'd0;
      r_wrcol   <= 7'd0;
      r_wrrow   <= 5'd0;
      r_valid   <= 1'b0;
    end else begin
      r_state <= w_nextState;
      r_rrPtr <= w_nextRrPtr;
      r_valid <= w_accept && !w_isNewline;
      if (w_accept && !w_isNewline) begin
        r_charsel <= w_acceptChar;
        r_wrcol   <= r_col;
        r_wrrow   <= r_row;
      end
    end
  end

  // Cursor. The write above always uses the pre-edge cursor, so a home that
  // coincides with an accept still writes at the old position; home then
  // overrides the increment.
  always_ff @(posedge phi or negedge rst_n) begin
    if (!rst_n) begin
      r_col <= 7'd0;
      r_row <= 5'd0;
    end else if (home) begin
      r_col <= 7'd0;
      r_row <= 5'd0;
    end else if (w_accept) begin
      if (w_isNewline || r_col == LAST_COL) begin
        r_col <= 7'd0;
        r_row <= (r_row == LAST_ROW) ? 5'd0 : r_row + 5'd1;
      end else begin
        r_col <= r_col + 7'd1;
      end
    end
  end

  assign charsel = r_charsel;
  assign wrcol   = r_wrcol;
  assign wrrow   = r_wrrow;
  assign valid   = r_valid;
  assign owner   = r_state;

endmodule

// File: tb/tb_text_write_sched.sv
// ============================================================================
// tb_text_write_sched
// ----------------------------------------------------------------------------
// Drives text_write_sched (default parameters: 80x30, NEWLINE=0x0A, vsync
// low opens the window) and compares every cycle against a reference model
// that keeps the cursor as one linear screen position and the owner as a
// plain integer.
// ============================================================================
module tb_text_write_sched;

  localparam int         COLS = 80;
  localparam int         ROWS = 30;
  localparam logic [6:0] NL   = 7'h0A;

  logic       phi;
  logic       rst_n;
  logic [6:0] a_char;
  logic       a_valid;
  logic       a_ready;
  logic [6:0] b_char;
  logic       b_valid;
  logic       b_ready;
  logic       vsync;
  logic       home;
  logic [6:0] charsel;
  logic [6:0] wrcol;
  logic [4:0] wrrow;
  logic       valid;
  logic [1:0] owner;

  int testsRun    = 0;
  int testsFailed = 0;

  // Reference model state: owner 0 idle / 1 A / 2 B, rr 0=A 1=B,
  // cursor as linear position row*COLS+col.
  logic [1:0] mOwner;
  int         mRr;
  int         mPos;
  logic       eValid;
  logic [6:0] eChar;
  logic [6:0] eCol;
  logic [4:0] eRow;
  logic [1:0] er;

  text_write_sched dut (
    .phi(phi), .rst_n(rst_n),
    .a_char(a_char), .a_valid(a_valid), .a_ready(a_ready),
    .b_char(b_char), .b_valid(b_valid), .b_ready(b_ready),
    .vsync(vsync), .home(home),
    .charsel(charsel), .wrcol(wrcol), .wrrow(wrrow),
    .valid(valid), .owner(owner)
  );

  initial phi = 1'b0;
  always #5 phi = ~phi;

  // Expected {a_ready, b_ready} from the current inputs and model owner.
  function automatic logic [1:0] expReady();
    logic win;
    win = (vsync == 1'b0) && rst_n;
    if (!win) return 2'b00;
    if (mOwner == 2'd0) begin
      if (a_valid && (!b_valid || mRr == 0)) return 2'b10;
      if (b_valid) return 2'b01;
      return 2'b00;
    end
    if (mOwner == 2'd1) return {a_valid, 1'b0};
    return {1'b0, b_valid};
  endfunction

  task automatic modelReset();
    mOwner = 2'd0;
    mRr    = 0;
    mPos   = 0;
    eValid = 1'b0;
    eChar  = 7'd0;
    eCol   = 7'd0;
    eRow   = 5'd0;
  endtask

  // Advance the model by one clock edge using the inputs now applied, then
  // move the bench to just after that edge.
  task automatic tick();
    logic [1:0] r;
    logic       accA, accB, acc, isNl, win, curValid;
    logic [6:0] chr;
    r    = expReady();
    accA = a_valid && r[1];
    accB = b_valid && r[0];
    acc  = accA || accB;
    chr  = accA ? a_char : b_char;
    isNl = acc && (chr == NL);
    win  = (vsync == 1'b0);
    if (acc && !isNl) begin
      eValid = 1'b1;
      eChar  = chr;
      eCol   = 7'(mPos % COLS);
      eRow   = 5'(mPos / COLS);
    end else begin
      eValid = 1'b0;
    end
    if (home) mPos = 0;
    else if (isNl) mPos = (((mPos / COLS) + 1) % ROWS) * COLS;
    else if (acc) mPos = (mPos + 1) % (COLS * ROWS);
    if (mOwner == 2'd0 && acc) mOwner = accA ? 2'd1 : 2'd2;
    curValid = (mOwner == 2'd1) ? a_valid : b_valid;
    if (mOwner != 2'd0 && (isNl || (win && !curValid))) begin
      mRr    = (mOwner == 2'd1) ? 1 : 0;
      mOwner = 2'd0;
    end
    @(posedge phi);
    #1;
  endtask

  task automatic idleInputs();
    a_valid = 1'b0; b_valid = 1'b0; a_char = 7'd0; b_char = 7'd0;
    vsync = 1'b0; home = 1'b0;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    idleInputs();
    @(posedge phi);
    #1;
    rst_n = 1'b1;
    modelReset();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idleInputs();
    a_valid = 1'b1; a_char = 7'h41;
    @(negedge phi);
    testsRun++;
    if ({a_ready, b_ready, valid, charsel, wrcol, wrrow, owner} !== 24'd0) begin
      testsFailed++;
      $display("[TB] FAIL reset: got %h want 000000",
               {a_ready, b_ready, valid, charsel, wrcol, wrrow, owner});
    end
    @(posedge phi);
    #1;
    rst_n = 1'b1;
    idleInputs();
    modelReset();
  endtask

  task automatic test_hello();
    logic [6:0] msg [2];
    msg[0] = 7'h48; msg[1] = 7'h49;
    doReset();
    for (int i = 0; i < 5; i++) begin
      a_valid = (i < 2);
      a_char  = (i < 2) ? msg[i] : 7'd0;
      @(negedge phi);
      er = expReady();
      testsRun++;
      if ({a_ready, b_ready, valid, charsel, wrcol, wrrow, owner} !==
          {er, eValid, eChar, eCol, eRow, mOwner}) begin
        testsFailed++;
        $display("[TB] FAIL hello cyc%0d: got %h want %h", i,
                 {a_ready, b_ready, valid, charsel, wrcol, wrrow, owner},
                 {er, eValid, eChar, eCol, eRow, mOwner});
      end
      if (i == 2) begin
        testsRun++;
        if ({valid, charsel, wrcol, wrrow, owner} !== {1'b1, 7'h49, 7'd1, 5'd0, 2'b01}) begin
          testsFailed++;
          $display("[TB] FAIL hello_I: got %h want %h",
                   {valid, charsel, wrcol, wrrow, owner},
                   {1'b1, 7'h49, 7'd1, 5'd0, 2'b01});
        end
      end
      tick();
    end
  endtask

  task automatic test_arbitration();
    doReset();
    for (int i = 0; i < 7; i++) begin
      a_valid = (i < 2);
      a_char  = (i == 0) ? 7'h58 : NL;
      b_valid = (i < 4);
      b_char  = 7'h51;
      @(negedge phi);
      er = expReady();
      testsRun++;
      if ({a_ready, b_ready, valid, charsel, wrcol, wrrow, owner} !==
          {er, eValid, eChar, eCol, eRow, mOwner}) begin
        testsFailed++;
        $display("[TB] FAIL arbitration cyc%0d: got %h want %h", i,
                 {a_ready, b_ready, valid, charsel, wrcol, wrrow, owner},
                 {er, eValid, eChar, eCol, eRow, mOwner});
      end
      tick();
    end
  endtask

  task automatic test_autowrap();
    doReset();
    for (int i = 0; i < 84; i++) begin
      a_valid = (i < 81);
      a_char  = 7'($urandom_range(32, 126));
      @(negedge phi);
      er = expReady();
      testsRun++;
      if ({a_ready, b_ready, valid, charsel, wrcol, wrrow, owner} !==
          {er, eValid, eChar, eCol, eRow, mOwner}) begin
        testsFailed++;
        $display("[TB] FAIL autowrap cyc%0d: got %h want %h", i,
                 {a_ready, b_ready, valid, charsel, wrcol, wrrow, owner},
                 {er, eValid, eChar, eCol, eRow, mOwner});
      end
      if (i == 81) begin
        testsRun++;
        if ({valid, wrcol, wrrow} !== {1'b1, 7'd0, 5'd1}) begin
          testsFailed++;
          $display("[TB] FAIL autowrap_81st: got %h want %h",
                   {valid, wrcol, wrrow}, {1'b1, 7'd0, 5'd1});
        end
      end
      tick();
    end
  endtask

  task automatic test_vsync_gate();
    doReset();
    for (int i = 0; i < 8; i++) begin
      a_valid = (i < 6);
      a_char  = 7'h61 + 7'(i);
      vsync   = (i < 3) || (i == 4);
      @(negedge phi);
      er = expReady();
      testsRun++;
      if ({a_ready, b_ready, valid, charsel, wrcol, wrrow, owner} !==
          {er, eValid, eChar, eCol, eRow, mOwner}) begin
        testsFailed++;
        $display("[TB] FAIL vsync_gate cyc%0d: got %h want %h", i,
                 {a_ready, b_ready, valid, charsel, wrcol, wrrow, owner},
                 {er, eValid, eChar, eCol, eRow, mOwner});
      end
      tick();
    end
  endtask

  task automatic test_rowwrap_home();
    doReset();
    for (int i = 0; i < 40; i++) begin
      a_valid = (i < 38);
      a_char  = (i < 30) ? NL : ((i == 35) ? 7'h5A : 7'h30 + 7'(i - 30));
      home    = (i == 35);
      @(negedge phi);
      er = expReady();
      testsRun++;
      if ({a_ready, b_ready, valid, charsel, wrcol, wrrow, owner} !==
          {er, eValid, eChar, eCol, eRow, mOwner}) begin
        testsFailed++;
        $display("[TB] FAIL rowwrap_home cyc%0d: got %h want %h", i,
                 {a_ready, b_ready, valid, charsel, wrcol, wrrow, owner},
                 {er, eValid, eChar, eCol, eRow, mOwner});
      end
      if (i == 36 || i == 37) begin
        testsRun++;
        if ({valid, charsel, wrcol, wrrow} !==
            ((i == 36) ? {1'b1, 7'h5A, 7'd5, 5'd0} : {1'b1, 7'h36, 7'd0, 5'd0})) begin
          testsFailed++;
          $display("[TB] FAIL home_pos cyc%0d: got %h", i, {valid, charsel, wrcol, wrrow});
        end
      end
      tick();
    end
    home = 1'b0;
  endtask

  task automatic test_reset_midline();
    doReset();
    for (int i = 0; i < 4; i++) begin
      b_valid = 1'b1;
      b_char  = 7'h70 + 7'(i);
      @(negedge phi);
      er = expReady();
      testsRun++;
      if ({a_ready, b_ready, valid, charsel, wrcol, wrrow, owner} !==
          {er, eValid, eChar, eCol, eRow, mOwner}) begin
        testsFailed++;
        $display("[TB] FAIL midline_pre cyc%0d: got %h want %h", i,
                 {a_ready, b_ready, valid, charsel, wrcol, wrrow, owner},
                 {er, eValid, eChar, eCol, eRow, mOwner});
      end
      tick();
    end
    rst_n = 1'b0;
    #1;
    testsRun++;
    if ({a_ready, b_ready, valid, charsel, wrcol, wrrow, owner} !== 24'd0) begin
      testsFailed++;
      $display("[TB] FAIL midline_reset: got %h want 000000",
               {a_ready, b_ready, valid, charsel, wrcol, wrrow, owner});
    end
    @(posedge phi);
    #1;
    rst_n = 1'b1;
    modelReset();
    for (int i = 0; i < 3; i++) begin
      b_valid = (i == 0);
      b_char  = 7'h4B;
      @(negedge phi);
      er = expReady();
      testsRun++;
      if ({a_ready, b_ready, valid, charsel, wrcol, wrrow, owner} !==
          {er, eValid, eChar, eCol, eRow, mOwner}) begin
        testsFailed++;
        $display("[TB] FAIL midline_post cyc%0d: got %h want %h", i,
                 {a_ready, b_ready, valid, charsel, wrcol, wrrow, owner},
                 {er, eValid, eChar, eCol, eRow, mOwner});
      end
      tick();
    end
  endtask

  task automatic test_random();
    doReset();
    for (int i = 0; i < 600; i++) begin
      vsync   = ($urandom_range(0, 3) == 0);
      home    = ($urandom_range(0, 40) == 0);
      a_valid = ($urandom_range(0, 3) != 0);
      b_valid = ($urandom_range(0, 2) != 0);
      a_char  = ($urandom_range(0, 7) == 0) ? NL : 7'($urandom_range(32, 126));
      b_char  = ($urandom_range(0, 7) == 0) ? NL : 7'($urandom_range(32, 126));
      @(negedge phi);
      er = expReady();
      testsRun++;
      if ({a_ready, b_ready, valid, charsel, wrcol, wrrow, owner} !==
          {er, eValid, eChar, eCol, eRow, mOwner}) begin
        testsFailed++;
        $display("[TB] FAIL random cyc%0d: got %h want %h", i,
                 {a_ready, b_ready, valid, charsel, wrcol, wrrow, owner},
                 {er, eValid, eChar, eCol, eRow, mOwner});
      end
      tick();
    end
    idleInputs();
  endtask

  initial begin
    rst_n = 1'b0;
    idleInputs();
    modelReset();
    #2;
    test_reset();
    test_hello();
    test_arbitration();
    test_autowrap();
    test_vsync_gate();
    test_rowwrap_home();
    test_reset_midline();
    test_random();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/text_write_sched.md
Name: text_write_sched

Overview:
- Arbitrates two character producers onto the single charsel/valid write channel of the text display.
- Each producer presents a 7-bit character with a valid/ready handshake; one of them is harmonica.
- Block tracks cursor column/row, generates wrcol/wrrow, handles newline and auto-wrap.
- Ownership is line-atomic, so lines from two producers never interleave; writes gated to vertical sync window.

Parameters:
- COLS, 80, characters per text row; wrcol range 0..COLS-1 (COLS <= 128).
- ROWS, 30, text rows; wrrow range 0..ROWS-1 (ROWS <= 32).
- NEWLINE, 7'h0A, character code treated as line terminator, never written to display.
- GATE_VSYNC, 1, 1: accept characters only while vsync==VS_ACT; 0: window always open.
- VS_ACT, 0, vsync level that marks the write window.

Ports:
- phi  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- a_char  in  7  producer A character
- a_valid  in  1  producer A character present
- a_ready  out  1  producer A character accepted this cycle (combinational)
- b_char  in  7  producer B character
- b_valid  in  1  producer B character present
- b_ready  out  1  producer B character accepted this cycle (combinational)
- vsync  in  1  display vertical sync, defines write window
- home  in  1  synchronous cursor home: col=0,row=0
- charsel  out  7  character to display, registered
- wrcol  out  7  write column, registered
- wrrow  out  5  write row, registered
- valid  out  1  one-cycle write strobe, registered
- owner  out  2  00 idle, 01 A, 10 B (state visibility)

Behaviour:
- Reset (async, rst_n=0): state IDLE, rr_ptr=A, col=0, row=0, charsel=0, wrcol=0, wrrow=0, valid=0, a_ready=b_ready=0, owner=00.
- win = GATE_VSYNC ? (vsync==VS_ACT) : 1.
- FSM states: IDLE, OWN_A, OWN_B.
- IDLE: when win and any valid, grant → OWN_A/OWN_B.
  - Both valid: rr_ptr wins.
  - Only one valid: that one wins.
  - Grant cycle also accepts that producer's first character.
- OWN_x: x_ready = win & x_valid; other producer's ready = 0.
  - Accept = x_valid & x_ready.
- Release to IDLE on the cycle that accepts NEWLINE, or on any cycle with x_valid=0 while win=1.
  - On release, rr_ptr points to the other producer.
- Window closes while owning: ownership held, ready=0, no release, resume when win returns.
- Accepted non-NEWLINE char: next cycle valid=1, charsel=char, wrcol=col, wrrow=row.
  - Then col+1; if col==COLS-1, col=0 and row+1.
- Accepted NEWLINE: valid=0 next cycle; col=0, row+1.
- Row wrap: row==ROWS-1 incrementing → 0.
- Latency: accept at edge N → valid high after edge N; one char per cycle maximum throughput.
- valid low on every cycle with no accept; charsel/wrcol/wrrow hold last values.
- home: col=0, row=0 at next edge. If home coincides with an accept, that char writes at the old position and the cursor is then forced to 0,0 (home wins over increment). Ownership is unaffected by home.
- Reset mid-line: immediate return to reset values; in-flight char discarded.

Test Plan:
- A sends "HI" with win open, B idle → valid pulses: charsel 7'h48 @col0 row0, then 7'h49 @col1 row0; owner=01 throughout.
- A and B both valid from reset → A wins (rr_ptr=A); A sends 'X',NEWLINE; then B's first char written @col0 row1; owner 01→00→10.
- 81 chars from A without newline, COLS=80 → 80th char @col79 row0, 81st @col0 row1.
- GATE_VSYNC=1, VS_ACT=0, vsync=1 while A valid → a_ready=0, valid=0; vsync drops → char accepted, valid 1 cycle later.
- Cursor at row29: NEWLINE → row0 col0; home asserted together with accept of 'Z' at col5 → 'Z' written @col5, cursor then 0,0.
- rst_n low mid-line, owner=10 → all outputs 0 immediately, owner=00; after release, B's next char written @col0 row0.
